// File: rtl/dea_sequencer.sv
// rtl/dea_sequencer.sv - frame parser and stepping front end for the DEA XOR cipher core
//
// Purpose: takes one frame at a time from a byte stream (key_len, key bytes,
// 16-bit little-endian message length, message bytes), loads the key into the
// DEA core, encrypts each message byte through it and returns the results on
// a valid/ready output stream.
//
// Ports:
//   dclk, reset            clock (rising edge) and synchronous active-low reset
//   s_data/s_valid/s_ready input byte stream
//   m_data/m_valid/m_ready encrypted byte stream
//   dea_reset              active-high reset to the DEA core
//   dea_kset/dea_din       key-load select and byte presented to the DEA
//   dea_step               one-cycle advance strobe for the DEA
//   dea_dout               registered DEA result, valid the cycle after dea_step
//   busy                   high whenever a frame is in progress
//   err                    one-cycle pulse on a malformed frame

module dea_sequencer #(
    parameter int MAX_KEY = 5,
    parameter int MAX_MSG = 1024,
    parameter int LEN_W   = 11
) (
    input  logic       dclk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       dea_reset,
    output logic       dea_kset,
    output logic [7:0] dea_din,
    output logic       dea_step,
    input  logic [7:0] dea_dout,
    output logic       busy,
    output logic       err
);

    localparam logic [7:0]  MAX_KEY_B = 8'(MAX_KEY);
    localparam logic [15:0] MAX_MSG_W = 16'(MAX_MSG);

    typedef enum logic [2:0] {
        IDLE,
        RST_DEA,
        KEY,
        LEN_LO,
        LEN_HI,
        MSG,
        CAP,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]       key_len;
    logic [2:0]       kcnt;
    logic [7:0]       len_lo;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] mcnt;

    logic             s_ready_i;
    logic             step_i;
    logic             kset_i;
    logic [7:0]       din_i;
    logic             rst_st;
    logic             err_set;
    logic             accept;

    logic [2:0]       kcnt_inc;
    logic [LEN_W-1:0] mcnt_inc;
    logic [15:0]      len_full;
    logic             bad_key;
    logic             bad_len;

    assign kcnt_inc = kcnt + 3'd1;
    assign mcnt_inc = mcnt + LEN_W'(1);
    // Range check uses the full 16 bits so values above MAX_MSG cannot alias
    // back into range once truncated to LEN_W.
    assign len_full = {s_data, len_lo};
    assign bad_key  = (s_data == 8'h00) || (s_data > MAX_KEY_B);
    assign bad_len  = (len_full == 16'h0000) || (len_full > MAX_MSG_W);
    assign accept   = s_valid && s_ready_i;

    always_ff @(posedge dclk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_ready_i  = 1'b0;
        step_i     = 1'b0;
        kset_i     = 1'b0;
        din_i      = 8'h00;
        rst_st     = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                s_ready_i = 1'b1;
                if (s_valid) begin
                    if (bad_key) begin
                        err_set = 1'b1;
                    end else begin
                        state_next = RST_DEA;
                    end
                end
            end
            RST_DEA: begin
                rst_st     = 1'b1;
                state_next = KEY;
            end
            KEY: begin
                s_ready_i = 1'b1;
                if (s_valid) begin
                    step_i = 1'b1;
                    kset_i = 1'b1;
                    din_i  = s_data;
                    if (kcnt_inc == key_len) begin
                        state_next = LEN_LO;
                    end
                end
            end
            LEN_LO: begin
                s_ready_i = 1'b1;
                if (s_valid) begin
                    state_next = LEN_HI;
                end
            end
            LEN_HI: begin
                s_ready_i = 1'b1;
                if (s_valid) begin
                    if (bad_len) begin
                        err_set    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = MSG;
                    end
                end
            end
            MSG: begin
                // Only take a new byte once the previous result can leave,
                // so CAP never overwrites an undelivered m_data.
                s_ready_i = !m_valid || m_ready;
                if (s_valid && s_ready_i) begin
                    step_i     = 1'b1;
                    din_i      = s_data;
                    state_next = CAP;
                end
            end
            CAP: begin
                state_next = (mcnt_inc == len) ? DRAIN : MSG;
            end
            DRAIN: begin
                if (m_valid && m_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge dclk) begin
        if (!reset) begin
            key_len <= 3'd0;
            kcnt    <= 3'd0;
            len_lo  <= 8'h00;
            len     <= '0;
            mcnt    <= '0;
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= err_set;
            case (state)
                IDLE: begin
                    if (accept && !bad_key) begin
                        key_len <= s_data[2:0];
                        kcnt    <= 3'd0;
                    end
                end
                KEY: begin
                    if (accept) begin
                        kcnt <= kcnt_inc;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_lo <= s_data;
                    end
                end
                LEN_HI: begin
                    if (accept && !bad_len) begin
                        len  <= len_full[LEN_W-1:0];
                        mcnt <= '0;
                    end
                end
                CAP: begin
                    m_data <= dea_dout;
                    mcnt   <= mcnt_inc;
                end
                default: begin
                end
            endcase
            if (state == CAP) begin
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Combinational outputs are forced to their idle values while reset is
    // held, since the state register only clears on the next edge.
    assign s_ready   = reset && s_ready_i;
    assign dea_step  = reset && step_i;
    assign dea_kset  = reset && kset_i;
    assign dea_din   = reset ? din_i : 8'h00;
    assign dea_reset = !reset || rst_st;
    assign busy      = reset && (state != IDLE);

endmodule

// File: tb/tb_dea_sequencer.sv
// tb/tb_dea_sequencer.sv - self-checking bench for dea_sequencer with a behavioural DEA core

module tb_dea_sequencer;

    logic       dclk;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       dea_reset;
    logic       dea_kset;
    logic [7:0] dea_din;
    logic       dea_step;
    logic [7:0] dea_dout;
    logic       busy;
    logic       err;

    dea_sequencer dut (
        .dclk      (dclk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .dea_reset (dea_reset),
        .dea_kset  (dea_kset),
        .dea_din   (dea_din),
        .dea_step  (dea_step),
        .dea_dout  (dea_dout),
        .busy      (busy),
        .err       (err)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    // Behavioural DEA: key store, key loaded on kset steps, cycled per byte.
    logic [7:0] keys [8];
    int         kload;
    int         midx;

    always @(posedge dclk) begin
        if (dea_reset) begin
            kload    <= 0;
            midx     <= 0;
            dea_dout <= 8'h00;
        end else if (dea_step) begin
            if (dea_kset) begin
                keys[kload[2:0]] <= dea_din;
                kload            <= kload + 1;
            end else begin
                dea_dout <= dea_din ^ keys[midx[2:0]];
                midx     <= (midx + 1 >= kload) ? 0 : midx + 1;
            end
        end
    end

    int checks;
    int errors;

    logic [7:0] out_q [$];
    logic [7:0] kdin_q [$];
    logic [7:0] in_q [$];
    logic [7:0] exp_q [$];
    int         err_cnt;
    int         rst_cnt;

    always @(negedge dclk) begin
        if (m_valid && m_ready) out_q.push_back(m_data);
        if (dea_step && dea_kset) kdin_q.push_back(dea_din);
        if (err) err_cnt = err_cnt + 1;
        if (dea_reset && reset) rst_cnt = rst_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        out_q.delete();
        kdin_q.delete();
        err_cnt = 0;
        rst_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done    = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge dclk);
            if (s_ready) done = 1'b1;
            @(posedge dclk);
            #1;
        end
        s_valid = 1'b0;
        if (!done) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL send_timeout: byte %0h not accepted", b);
        end
    endtask

    task automatic drive_all();
        for (int i = 0; i < in_q.size(); i++) send_byte(in_q[i]);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge dclk);
            if (!busy && !m_valid) done = 1'b1;
        end
        check({name, " idle_reached"}, {31'd0, done}, 32'd1);
        @(posedge dclk);
        #1;
    endtask

    task automatic check_results(input string name, input int n_err, input int n_kset, input int n_rst);
        logic [7:0] a;
        check({name, " out_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            a = (i < out_q.size()) ? out_q[i] : 8'hxx;
            check($sformatf("%s out[%0d]", name, i), {24'd0, a}, {24'd0, exp_q[i]});
        end
        check({name, " err_pulses"}, err_cnt, n_err);
        check({name, " kset_steps"}, kdin_q.size(), n_kset);
        for (int i = 0; i < n_kset && i < kdin_q.size(); i++)
            check($sformatf("%s key_din[%0d]", name, i), {24'd0, kdin_q[i]}, {24'd0, in_q[1 + i]});
        check({name, " dea_reset_pulses"}, rst_cnt, n_rst);
    endtask

    task automatic run_frame(input string name, input int n_err, input int n_kset, input int n_rst);
        clear_mon();
        drive_all();
        wait_idle(name);
        check_results(name, n_err, n_kset, n_rst);
    endtask

    typedef struct {
        string        name;
        logic [127:0] ins;
        int           n_in;
        logic [63:0]  outs;
        int           n_out;
        int           n_err;
        int           n_kset;
        int           n_rst;
    } vec_t;

    vec_t vecs [8];

    task automatic load_vec(input vec_t v);
        in_q.delete();
        exp_q.delete();
        for (int i = 0; i < v.n_in; i++) in_q.push_back(v.ins[8*(v.n_in-1-i) +: 8]);
        for (int i = 0; i < v.n_out; i++) exp_q.push_back(v.outs[8*(v.n_out-1-i) +: 8]);
    endtask

    logic [7:0] kk [5];

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        m_ready = 1'b1;
        clear_mon();

        vecs[0] = '{"basic",     128'h02414202006869,     7,  64'h292B,     2, 0, 2, 1};
        vecs[1] = '{"key_wrap",  128'h01FF0300000FF0,     7,  64'hFFF00F,   3, 0, 1, 1};
        vecs[2] = '{"klen_0",    128'h00,                 1,  64'h0,        0, 1, 0, 0};
        vecs[3] = '{"klen_6",    128'h06,                 1,  64'h0,        0, 1, 0, 0};
        vecs[4] = '{"len_1025",  128'h01AA0104,           4,  64'h0,        0, 1, 1, 1};
        vecs[5] = '{"after_err", 128'h03102030040001020304, 10, 64'h11223314, 4, 0, 3, 1};
        vecs[6] = '{"klen_5",    128'h0501020304050100FF, 9,  64'hFE,       1, 0, 5, 1};
        vecs[7] = '{"len_0",     128'h01550000,           4,  64'h0,        0, 1, 1, 1};

        // Reset state
        repeat (3) @(posedge dclk);
        @(negedge dclk);
        check("rst s_ready",   {31'd0, s_ready},   32'd0);
        check("rst m_valid",   {31'd0, m_valid},   32'd0);
        check("rst dea_step",  {31'd0, dea_step},  32'd0);
        check("rst dea_kset",  {31'd0, dea_kset},  32'd0);
        check("rst busy",      {31'd0, busy},      32'd0);
        check("rst err",       {31'd0, err},       32'd0);
        check("rst m_data",    {24'd0, m_data},    32'd0);
        check("rst dea_din",   {24'd0, dea_din},   32'd0);
        check("rst dea_reset", {31'd0, dea_reset}, 32'd1);
        @(posedge dclk);
        #1;
        reset = 1'b1;
        @(negedge dclk);
        check("idle s_ready",   {31'd0, s_ready},   32'd1);
        check("idle dea_reset", {31'd0, dea_reset}, 32'd0);
        @(posedge dclk);
        #1;

        // Table-driven frames
        for (int v = 0; v < 8; v++) begin
            load_vec(vecs[v]);
            run_frame(vecs[v].name, vecs[v].n_err, vecs[v].n_kset, vecs[v].n_rst);
        end

        // Backpressure: hold m_ready low for 5 cycles after the first m_valid
        load_vec(vecs[0]);
        clear_mon();
        m_ready = 1'b0;
        fork
            drive_all();
            begin
                bit seen;
                seen = 1'b0;
                for (int c = 0; c < 200 && !seen; c++) begin
                    @(negedge dclk);
                    if (m_valid) seen = 1'b1;
                end
                check("bp first_valid", {31'd0, seen}, 32'd1);
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge dclk);
                    check($sformatf("bp m_data[%0d]", c),   {24'd0, m_data},   32'h29);
                    check($sformatf("bp s_ready[%0d]", c),  {31'd0, s_ready},  32'd0);
                    check($sformatf("bp dea_step[%0d]", c), {31'd0, dea_step}, 32'd0);
                end
                @(posedge dclk);
                #1;
                m_ready = 1'b1;
            end
        join
        wait_idle("bp");
        check_results("bp", 0, 2, 1);

        // Reset in the middle of a 3-byte message
        in_q = '{8'h01, 8'hAA, 8'h03, 8'h00, 8'h11};
        clear_mon();
        drive_all();
        @(posedge dclk);
        #1;
        reset = 1'b0;
        @(negedge dclk);
        check("midrst dea_reset", {31'd0, dea_reset}, 32'd1);
        check("midrst s_ready",   {31'd0, s_ready},   32'd0);
        check("midrst busy",      {31'd0, busy},      32'd0);
        check("midrst dea_step",  {31'd0, dea_step},  32'd0);
        @(posedge dclk);
        @(negedge dclk);
        check("midrst m_valid", {31'd0, m_valid}, 32'd0);
        check("midrst m_data",  {24'd0, m_data},  32'd0);
        check("midrst err",     {31'd0, err},     32'd0);
        @(posedge dclk);
        #1;
        reset = 1'b1;
        @(posedge dclk);
        #1;
        in_q  = '{8'h01, 8'h5A, 8'h02, 8'h00, 8'h11, 8'h22};
        exp_q = '{8'h4B, 8'h78};
        run_frame("post_rst", 0, 1, 1);

        // Maximum key and message length
        kk = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        in_q.delete();
        exp_q.delete();
        in_q.push_back(8'h05);
        for (int i = 0; i < 5; i++) in_q.push_back(kk[i]);
        in_q.push_back(8'h00);
        in_q.push_back(8'h04);
        for (int i = 0; i < 1024; i++) begin
            logic [7:0] mb;
            mb = 8'((i * 7 + 3) ^ (i >> 8));
            in_q.push_back(mb);
            exp_q.push_back(mb ^ kk[i % 5]);
        end
        clear_mon();
        drive_all();
        wait_idle("max");
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 1024; i++)
                if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
            check("max out_count", out_q.size(), 1024);
            check("max out_mismatches", bad, 0);
            check("max err_pulses", err_cnt, 0);
            check("max kset_steps", kdin_q.size(), 5);
            check("max busy_end", {31'd0, busy}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dea_sequencer.md
Name: dea_sequencer

Overview:
- Frame-level controller that feeds the DEA XOR cipher core from a byte-stream source. It parses one frame at a time: key length, key bytes, 16-bit message length, then message bytes.
- It drives the DEA `kset`/`din` controls with a one-cycle advance strobe.
- It returns each encrypted byte on a valid/ready output stream.
- It replaces the bench-style hand sequencing of `kset` and `din` with a synthesizable front end.

Parameters:
- MAX_KEY, 5, maximum key bytes accepted (matches DEA key store depth).
- MAX_MSG, 1024, maximum message bytes per frame.
- LEN_W, 11, width of the message byte counter (must hold MAX_MSG).

Ports:
- dclk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- s_data  input  8  incoming frame byte.
- s_valid  input  1  s_data valid.
- s_ready  output  1  controller accepts s_data this cycle.
- m_data  output  8  encrypted byte.
- m_valid  output  1  m_data valid.
- m_ready  input  1  downstream accepts m_data.
- dea_reset  output  1  active-high reset to the DEA core.
- dea_kset  output  1  1 = the current strobe loads a key byte; 0 = it encrypts.
- dea_din  output  8  byte presented to the DEA.
- dea_step  output  1  one-cycle enable; the DEA advances on dclk when high.
- dea_dout  input  8  DEA result, registered, valid the cycle after dea_step.
- busy  output  1  high in every state except IDLE.
- err  output  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset (reset == 0 at a dclk edge):
  - State goes to IDLE and all counters clear.
  - s_ready, m_valid, dea_step, dea_kset, busy and err are 0; m_data and dea_din are 0x00.
  - dea_reset is 1 while reset is low and during the RST_DEA state, otherwise 0.
  - Reset mid-frame abandons the frame; the partial output byte is dropped.
- Handshakes:
  - An input byte transfers when s_valid && s_ready at a rising edge.
  - An output byte transfers when m_valid && m_ready at a rising edge.
  - m_data is held stable while m_valid && !m_ready.
- IDLE (s_ready = 1): accept the key_len byte.
  - If key_len is 0 or greater than MAX_KEY: pulse err and stay in IDLE.
  - Otherwise store key_len and go to RST_DEA.
- RST_DEA (s_ready = 0): dea_reset = 1 for exactly one cycle, clearing stale keys; then go to KEY.
- KEY (s_ready = 1):
  - Each accepted byte drives dea_din = s_data, dea_kset = 1, dea_step = 1 in the same cycle (combinational from the accepted byte) and increments kcnt.
  - After key_len bytes, go to LEN_LO.
- LEN_LO (s_ready = 1): latch the low length byte; go to LEN_HI.
- LEN_HI (s_ready = 1): form len = {hi, lo}.
  - If len is 0 or greater than MAX_MSG: pulse err and go to IDLE.
  - Otherwise clear mcnt and go to MSG.
- MSG: s_ready = (!m_valid || m_ready).
  - An accepted byte drives dea_din = s_data, dea_kset = 0, dea_step = 1; then go to CAP.
- CAP (s_ready = 0):
  - Load m_data <= dea_dout, set m_valid = 1, increment mcnt.
  - If mcnt == len (post-increment), go to DRAIN; else go to MSG.
  - An m_valid already pending is guaranteed to have drained by this cycle, because MSG gated on it.
- DRAIN (s_ready = 0): wait for the final output handshake; then go to IDLE.
- m_valid deasserts the cycle after a handshake unless CAP reloads it in that same cycle.
- Throughput and latency:
  - At most one message byte is in flight.
  - Peak rate is 1 byte per 2 cycles.
  - Input accept to m_valid is 2 edges.
- Key cycling (byte i uses key[i mod key_len]) is the DEA's responsibility; the controller never re-sends keys within a frame.
- dea_step is never asserted in IDLE, RST_DEA, LEN_LO, LEN_HI, CAP or DRAIN.
- Width rules:
  - kcnt is 3 bits.
  - mcnt and len compare use LEN_W bits; the high length byte is checked before truncation, so any value above MAX_MSG is an error.

Test Plan:
- Basic frame, m_ready held 1:
  - Stimulus: 0x02, 0x41, 0x42, 0x02, 0x00, 0x68, 0x69.
  - Required: exactly two dea_step with dea_kset = 1 (din 0x41, 0x42), then m_data 0x29, 0x2B; then busy = 0.
- Key wrap:
  - Stimulus: 0x01, 0xFF, 0x03, 0x00, 0x00, 0x0F, 0xF0.
  - Required: outputs 0xFF, 0xF0, 0x0F; exactly one dea_reset pulse after key_len is accepted.
- Malformed frames:
  - key_len 0x00 -> err pulses 1 cycle, state IDLE.
  - key_len 0x06 -> err pulses.
  - Length 0x0401 (1025) -> err pulses after LEN_HI.
  - A following valid frame encrypts correctly.
- Backpressure:
  - Stimulus: basic frame with m_ready = 0 for 5 cycles after the first m_valid.
  - Required: m_data stays 0x29, s_ready stays 0, no dea_step; on release, 0x2B follows.
- Reset mid-message:
  - Stimulus: drive reset = 0 after 1 of 3 message bytes.
  - Required: next cycle all outputs at reset values, dea_reset = 1; a new frame afterwards produces correct output using only the new key.
- Max lengths:
  - Stimulus: key_len 5 with a 1024-byte message.
  - Required: 1024 outputs equal to msg[i] ^ key[i%5]; mcnt has no overflow; DRAIN then IDLE.
